// File: rtl/mtr_drv_if.sv
// rtl/mtr_drv_if.sv - command and PWM signal bundle for the motor drive stage
interface mtr_drv_if;
    logic        pwr_up;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic        lft_pwm_a;
    logic        lft_pwm_b;
    logic        rght_pwm_a;
    logic        rght_pwm_b;
    logic        prd_strt;

    modport master (
        output pwr_up, lft_spd, rght_spd,
        input  lft_pwm_a, lft_pwm_b, rght_pwm_a, rght_pwm_b, prd_strt
    );

    modport slave (
        input  pwr_up, lft_spd, rght_spd,
        output lft_pwm_a, lft_pwm_b, rght_pwm_a, rght_pwm_b, prd_strt
    );
endinterface

// File: rtl/mtr_drv.sv
// rtl/mtr_drv.sv - dual H-bridge PWM drive with period-aligned commands and reversal dead time
module mtr_drv #(
    parameter int PWM_W    = 11,
    parameter int DEAD_CYC = 32
) (
    input  logic      clk,
    input  logic      rst,
    mtr_drv_if.slave  bus
);
    localparam int               DW       = $clog2(DEAD_CYC + 1);
    localparam logic [PWM_W-1:0] CNT_MAX  = '1;
    localparam logic [12:0]      MAG_MAX  = 13'((1 << PWM_W) - 1);
    localparam logic [DW-1:0]    DEAD_LD  = DW'(DEAD_CYC - 1);
    localparam logic [0:0]       ST_RUN   = 1'b0;
    localparam logic [0:0]       ST_DEAD  = 1'b1;
    localparam logic             DIR_FWD  = 1'b0;
    localparam logic             DIR_REV  = 1'b1;

    logic [PWM_W-1:0] cnt_q, cnt_d;
    logic             wrap;
    logic             wrap_q, wrap_d;
    logic             prd_strt_q, prd_strt_d;

    // index 0 is the left wheel, index 1 the right wheel
    logic [11:0]      spd      [2];
    logic             new_dir  [2];
    logic [PWM_W-1:0] duty_q   [2];
    logic [PWM_W-1:0] duty_d   [2];
    logic             dir_q    [2];
    logic             dir_d    [2];
    logic [0:0]       st_q     [2];
    logic [0:0]       st_d     [2];
    logic [DW-1:0]    dead_q   [2];
    logic [DW-1:0]    dead_d   [2];
    logic             pwm_a_q  [2];
    logic             pwm_a_d  [2];
    logic             pwm_b_q  [2];
    logic             pwm_b_d  [2];

    assign spd[0] = bus.lft_spd;
    assign spd[1] = bus.rght_spd;

    // Widen to 13 bits so that -2048 negates cleanly before saturation.
    function automatic logic [PWM_W-1:0] spd_mag(input logic [11:0] s);
        logic [12:0] ext;
        logic [12:0] abs_v;
        ext   = {s[11], s};
        abs_v = s[11] ? (13'd0 - ext) : ext;
        return (abs_v > MAG_MAX) ? MAG_MAX[PWM_W-1:0] : abs_v[PWM_W-1:0];
    endfunction

    always_comb begin
        wrap       = bus.pwr_up && (cnt_q == CNT_MAX);
        cnt_d      = bus.pwr_up ? cnt_q + PWM_W'(1) : '0;
        wrap_d     = wrap;
        prd_strt_d = bus.pwr_up && wrap_q;

        for (int c = 0; c < 2; c++) begin
            new_dir[c] = spd[c][11] ? DIR_REV :
                         ((spd[c] != 12'd0) ? DIR_FWD : dir_q[c]);
            duty_d[c]  = duty_q[c];
            dir_d[c]   = dir_q[c];
            st_d[c]    = st_q[c];
            dead_d[c]  = dead_q[c];

            if (!bus.pwr_up) begin
                duty_d[c] = '0;
                dir_d[c]  = DIR_FWD;
                st_d[c]   = ST_RUN;
                dead_d[c] = '0;
            end else begin
                if (st_q[c] == ST_DEAD) begin
                    if (dead_q[c] == '0)
                        st_d[c] = ST_RUN;
                    else
                        dead_d[c] = dead_q[c] - DW'(1);
                end
                if (wrap) begin
                    duty_d[c] = spd_mag(spd[c]);
                    dir_d[c]  = new_dir[c];
                    if (new_dir[c] != dir_q[c]) begin
                        st_d[c]   = ST_DEAD;
                        dead_d[c] = DEAD_LD;
                    end
                end
            end

            // Dead time masks the low counts of the period, so the pulse is shortened rather than delayed.
            pwm_a_d[c] = bus.pwr_up && (st_q[c] == ST_RUN) && (dir_q[c] == DIR_FWD)
                         && (cnt_q < duty_q[c]);
            pwm_b_d[c] = bus.pwr_up && (st_q[c] == ST_RUN) && (dir_q[c] == DIR_REV)
                         && (cnt_q < duty_q[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            wrap_q     <= 1'b0;
            prd_strt_q <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                duty_q[c]  <= '0;
                dir_q[c]   <= DIR_FWD;
                st_q[c]    <= ST_RUN;
                dead_q[c]  <= '0;
                pwm_a_q[c] <= 1'b0;
                pwm_b_q[c] <= 1'b0;
            end
        end else begin
            cnt_q      <= cnt_d;
            wrap_q     <= wrap_d;
            prd_strt_q <= prd_strt_d;
            for (int c = 0; c < 2; c++) begin
                duty_q[c]  <= duty_d[c];
                dir_q[c]   <= dir_d[c];
                st_q[c]    <= st_d[c];
                dead_q[c]  <= dead_d[c];
                pwm_a_q[c] <= pwm_a_d[c];
                pwm_b_q[c] <= pwm_b_d[c];
            end
        end
    end

    assign bus.lft_pwm_a  = pwm_a_q[0];
    assign bus.lft_pwm_b  = pwm_b_q[0];
    assign bus.rght_pwm_a = pwm_a_q[1];
    assign bus.rght_pwm_b = pwm_b_q[1];
    assign bus.prd_strt   = prd_strt_q;
endmodule

// File: tb/tb_mtr_drv.sv
// tb/tb_mtr_drv.sv - scoreboard bench for mtr_drv against a period-level reference model
module tb_mtr_drv;
    localparam int PWM_W    = 11;
    localparam int DEAD_CYC = 32;
    localparam int PERIOD   = 1 << PWM_W;
    localparam int MAXC     = PERIOD - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mtr_drv_if bus();

    mtr_drv #(.PWM_W(PWM_W), .DEAD_CYC(DEAD_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [4:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Model: position in period, active duty/direction, and whether this period began with a reversal.
    int m_cnt;
    int m_duty [2];
    bit m_rev  [2];
    bit m_dead [2];
    bit m_wrap;

    function automatic void model_clear();
        m_cnt  = 0;
        m_wrap = 0;
        for (int c = 0; c < 2; c++) begin
            m_duty[c] = 0;
            m_rev[c]  = 0;
            m_dead[c] = 0;
        end
    endfunction

    function automatic logic [4:0] model_step();
        logic [4:0] e;
        int v, mag;
        bit nrev, on;
        e = '0;
        if (rst || !bus.pwr_up) begin
            model_clear();
            return e;
        end
        for (int c = 0; c < 2; c++) begin
            on = (m_cnt < m_duty[c]) && !(m_dead[c] && m_cnt < DEAD_CYC);
            e[4 - 2*c] = on && !m_rev[c];
            e[3 - 2*c] = on && m_rev[c];
        end
        e[0] = m_wrap;
        if (m_cnt == MAXC) begin
            for (int c = 0; c < 2; c++) begin
                v    = (c == 0) ? int'($signed(bus.lft_spd)) : int'($signed(bus.rght_spd));
                mag  = (v < 0) ? -v : v;
                if (mag > MAXC) mag = MAXC;
                nrev = (v < 0) ? 1'b1 : ((v > 0) ? 1'b0 : m_rev[c]);
                m_dead[c] = (nrev != m_rev[c]);
                m_rev[c]  = nrev;
                m_duty[c] = mag;
            end
            m_cnt  = 0;
            m_wrap = 1;
        end else begin
            m_cnt  = m_cnt + 1;
            m_wrap = 0;
        end
        return e;
    endfunction

    task automatic step();
        exp_q.push_back(model_step());
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic run_to(input int k);
        int guard = 0;
        while (m_cnt != k && guard < 2 * PERIOD) begin
            step();
            guard++;
        end
        n_cmp++;
        if (m_cnt != k) begin
            n_err++;
            $display("FAIL run_to_timeout cnt=%0d required=%0d", m_cnt, k);
        end
    endtask

    function automatic logic [11:0] pick_spd();
        case ($urandom_range(0, 7))
            0: return 12'h7FF;
            1: return 12'h800;
            2: return 12'hFFF;
            3: return 12'h001;
            4: return 12'h000;
            default: return 12'($urandom);
        endcase
    endfunction

    initial begin : monitor
        logic [4:0] e, got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {bus.lft_pwm_a, bus.lft_pwm_b, bus.rght_pwm_a, bus.rght_pwm_b, bus.prd_strt};
                n_cmp++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL outputs t=%0t {la,lb,ra,rb,prd} got=%b required=%b", $time, got, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        assert (!(bus.lft_pwm_a && bus.lft_pwm_b) && !(bus.rght_pwm_a && bus.rght_pwm_b))
        else begin
            n_err++;
            $display("FAIL bridge_overlap t=%0t l=%b%b r=%b%b required no pair high", $time,
                     bus.lft_pwm_a, bus.lft_pwm_b, bus.rght_pwm_a, bus.rght_pwm_b);
        end
    end

    initial begin : stim
        model_clear();
        rst          = 1'b1;
        bus.pwr_up   = 1'b1;
        bus.lft_spd  = 12'h200;
        bus.rght_spd = 12'h800;
        @(negedge clk);
        steps(3);
        rst = 1'b0;
        steps(3 * PERIOD);

        bus.lft_spd = 12'h100;
        run_to(0);
        steps(PERIOD + 500);
        bus.lft_spd = 12'hF00;
        steps(3 * PERIOD);

        bus.lft_spd = 12'h100;
        steps(2 * PERIOD);
        bus.lft_spd = 12'h000;
        steps(2 * PERIOD);
        bus.lft_spd = 12'h050;
        steps(PERIOD + 100);

        bus.lft_spd = 12'h3E8;
        run_to(0);
        steps(PERIOD);
        run_to(500);
        bus.pwr_up = 1'b0;
        steps(20);
        bus.pwr_up = 1'b1;
        steps(2 * PERIOD + 50);

        bus.rght_spd = 12'h300;
        run_to(0);
        steps(PERIOD);
        run_to(100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        steps(PERIOD + 50);

        for (int p = 0; p < 12; p++) begin
            steps($urandom_range(200, 2500));
            bus.lft_spd  = pick_spd();
            bus.rght_spd = pick_spd();
            if ($urandom_range(0, 5) == 0) begin
                bus.pwr_up = 1'b0;
                steps($urandom_range(1, 8));
                bus.pwr_up = 1'b1;
            end
        end
        steps(PERIOD);

        @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain left=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
